// File: rtl/fasm_arb_pkg.sv
// Shared constants for the two-master SRAM port arbiter: grant encoding and
// the reset value of the round-robin "last served" register.
package fasm_arb_pkg;

  typedef logic gnt_t;

  localparam gnt_t GNT_A = 1'b0;
  localparam gnt_t GNT_B = 1'b1;

  // Last-served starts at B so that A wins the first contention after reset.
  localparam gnt_t LAST_RST = GNT_B;

endpackage

// File: rtl/fasm_rrarb2.sv
// Two-input round-robin grant: picks the eligible master, or the one that was
// not served last when both are eligible.
module fasm_rrarb2
  import fasm_arb_pkg::*;
(
  input  logic elig_a_i,
  input  logic elig_b_i,
  input  gnt_t last_i,
  output logic issue_o,
  output gnt_t gnt_o
);

  always_comb begin
    issue_o = elig_a_i | elig_b_i;
    gnt_o   = GNT_A;
    if (elig_a_i && elig_b_i) begin
      gnt_o = (last_i == GNT_A) ? GNT_B : GNT_A;
    end else if (elig_b_i) begin
      gnt_o = GNT_B;
    end
  end

endmodule

// File: rtl/fasm_dpsram_arb2.sv
// Shares one synchronous SRAM port between two Wishbone-classic masters with
// round-robin arbitration; ack and read data return one cycle after issue.
module fasm_dpsram_arb2
  import fasm_arb_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,

  input  logic          a_stb_i,
  input  logic          a_wre_i,
  input  logic [AW-1:0] a_adr_i,
  input  logic [DW-1:0] a_dat_i,
  output logic [DW-1:0] a_dat_o,
  output logic          a_ack_o,

  input  logic          b_stb_i,
  input  logic          b_wre_i,
  input  logic [AW-1:0] b_adr_i,
  input  logic [DW-1:0] b_dat_i,
  output logic [DW-1:0] b_dat_o,
  output logic          b_ack_o,

  output logic          mem_stb_o,
  output logic          mem_wre_o,
  output logic [AW-1:0] mem_adr_o,
  output logic [DW-1:0] mem_dat_o,
  input  logic [DW-1:0] mem_dat_i
);

  gnt_t last_q, last_d;
  logic ack_a_q, ack_a_d;
  logic ack_b_q, ack_b_d;

  logic elig_a, elig_b;
  logic issue;
  gnt_t gnt;

  // During its ack cycle a master's strobe still belongs to the finished
  // access, so it must not be re-issued.
  assign elig_a = a_stb_i & ~ack_a_q;
  assign elig_b = b_stb_i & ~ack_b_q;

  fasm_rrarb2 u_rrarb (
    .elig_a_i (elig_a),
    .elig_b_i (elig_b),
    .last_i   (last_q),
    .issue_o  (issue),
    .gnt_o    (gnt)
  );

  always_comb begin
    last_d  = last_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    if (issue) begin
      last_d  = gnt;
      ack_a_d = (gnt == GNT_A);
      ack_b_d = (gnt == GNT_B);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q  <= LAST_RST;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      ack_a_q <= ack_a_d;
      ack_b_q <= ack_b_d;
    end
  end

  // Idle cycles leave the grant at A, so address/data mux follows master A.
  always_comb begin
    mem_stb_o = issue;
    if (gnt == GNT_B) begin
      mem_wre_o = issue & b_wre_i;
      mem_adr_o = b_adr_i;
      mem_dat_o = b_dat_i;
    end else begin
      mem_wre_o = issue & a_wre_i;
      mem_adr_o = a_adr_i;
      mem_dat_o = a_dat_i;
    end
  end

  assign a_ack_o = ack_a_q;
  assign b_ack_o = ack_b_q;
  assign a_dat_o = mem_dat_i;
  assign b_dat_o = mem_dat_i;

endmodule

// File: tb/tb_fasm_dpsram_arb2.sv
// Self-checking bench for fasm_dpsram_arb2: directed scenarios plus random
// traffic compared against a transaction-level model of the arbiter and SRAM.
module tb_fasm_dpsram_arb2;

  localparam int AW = 8;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          stb [2];
  logic          wre [2];
  logic [AW-1:0] adr [2];
  logic [DW-1:0] wdat[2];

  logic [DW-1:0] a_dout, b_dout;
  logic          a_ack, b_ack;
  logic          mem_stb, mem_wre;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_dat, ram_q;

  fasm_dpsram_arb2 #(.AW(AW), .DW(DW)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .a_stb_i   (stb[0]),
    .a_wre_i   (wre[0]),
    .a_adr_i   (adr[0]),
    .a_dat_i   (wdat[0]),
    .a_dat_o   (a_dout),
    .a_ack_o   (a_ack),
    .b_stb_i   (stb[1]),
    .b_wre_i   (wre[1]),
    .b_adr_i   (adr[1]),
    .b_dat_i   (wdat[1]),
    .b_dat_o   (b_dout),
    .b_ack_o   (b_ack),
    .mem_stb_o (mem_stb),
    .mem_wre_o (mem_wre),
    .mem_adr_o (mem_adr),
    .mem_dat_o (mem_dat),
    .mem_dat_i (ram_q)
  );

  // Environment SRAM port: write-before-read, 1-cycle read latency.
  logic [DW-1:0] ram [2**AW];
  always @(posedge clk) begin
    if (mem_stb) begin
      if (mem_wre) begin
        ram[mem_adr] <= mem_dat;
        ram_q        <= mem_dat;
      end else begin
        ram_q <= ram[mem_adr];
      end
    end
  end

  // Reference model state
  logic          exp_ack[2];
  logic          exp_wr [2];
  logic [DW-1:0] exp_rd;
  logic          last_m;
  logic [DW-1:0] mmem [2**AW];

  int total = 0;
  int bad = 0;
  int acks_seen[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic sample_acks();
    chk("a_ack", {63'd0, a_ack}, {63'd0, exp_ack[0]});
    chk("b_ack", {63'd0, b_ack}, {63'd0, exp_ack[1]});
    chk("ack_excl", {63'd0, a_ack & b_ack}, 64'd0);
    if (exp_ack[0] && !exp_wr[0]) chk("a_rdata", {32'd0, a_dout}, {32'd0, exp_rd});
    if (exp_ack[1] && !exp_wr[1]) chk("b_rdata", {32'd0, b_dout}, {32'd0, exp_rd});
    if (a_ack === 1'b1) acks_seen[0]++;
    if (b_ack === 1'b1) acks_seen[1]++;
    for (int m = 0; m < 2; m++) if (exp_ack[m]) stb[m] = 1'b0;
  endtask

  task automatic eval_cycle();
    logic e0, e1, issue;
    int g;
    #1;
    e0 = stb[0] & ~exp_ack[0];
    e1 = stb[1] & ~exp_ack[1];
    issue = e0 | e1;
    if (e0 && e1) g = last_m ? 0 : 1;
    else if (e1)  g = 1;
    else          g = 0;
    chk("mem_stb", {63'd0, mem_stb}, {63'd0, issue});
    chk("mem_wre", {63'd0, mem_wre}, {63'd0, issue & wre[g]});
    chk("mem_adr", {56'd0, mem_adr}, {56'd0, adr[g]});
    chk("mem_dat", {32'd0, mem_dat}, {32'd0, wdat[g]});
    $display("cyc t=%0t stb=%0b%0b issue=%0b gnt=%0d adr=%0h", $time, stb[0], stb[1], issue, g, adr[g]);
    exp_ack[0] = issue && (g == 0);
    exp_ack[1] = issue && (g == 1);
    if (issue) begin
      last_m    = (g == 1);
      exp_wr[g] = wre[g];
      if (wre[g]) begin
        mmem[adr[g]] = wdat[g];
        exp_rd       = wdat[g];
      end else begin
        exp_rd = mmem[adr[g]];
      end
    end
  endtask

  task automatic new_req(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    stb[m] = 1'b1; wre[m] = w; adr[m] = a; wdat[m] = d;
  endtask

  task automatic step();
    @(negedge clk);
    sample_acks();
  endtask

  // mode 0: no new requests, 1: both saturate, 2: random traffic
  task automatic cyc(input int mode);
    step();
    for (int m = 0; m < 2; m++) begin
      if (!stb[m] && (mode == 1 || (mode == 2 && $urandom_range(1, 0) == 1)))
        new_req(m, 1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)), $urandom);
    end
    eval_cycle();
  endtask

  task automatic model_reset();
    exp_ack[0] = 1'b0; exp_ack[1] = 1'b0;
    last_m = 1'b1;
  endtask

  task automatic do_reset();
    stb[0] = 1'b0; stb[1] = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_a_ack", {63'd0, a_ack}, 64'd0);
    chk("rst_b_ack", {63'd0, b_ack}, 64'd0);
    chk("rst_mem_stb", {63'd0, mem_stb}, 64'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      stb[i] = 1'b0; wre[i] = 1'b0; adr[i] = '0; wdat[i] = '0;
      exp_wr[i] = 1'b0; acks_seen[i] = 0;
    end
    exp_rd = '0;
    for (int i = 0; i < 2**AW; i++) begin
      ram[i]  = 32'hA5A5_0000 ^ DW'(i * 32'h0101_0101);
      mmem[i] = 32'hA5A5_0000 ^ DW'(i * 32'h0101_0101);
    end
    ram[8'h10]  = 32'hDEAD_BEEF;
    mmem[8'h10] = 32'hDEAD_BEEF;
    model_reset();

    // Reset then lone A read
    do_reset();
    step();
    new_req(0, 1'b0, 8'h10, '0);
    eval_cycle();
    chk("t1_issue", {63'd0, mem_stb}, 64'd1);
    step();
    chk("t1_ack", {63'd0, a_ack}, 64'd1);
    chk("t1_dat", {32'd0, a_dout}, {32'd0, 32'hDEAD_BEEF});
    chk("t1_b_ack", {63'd0, b_ack}, 64'd0);
    eval_cycle();

    // Simultaneous first requests: A first, then B
    do_reset();
    step();
    new_req(0, 1'b0, 8'h01, '0);
    new_req(1, 1'b0, 8'h02, '0);
    eval_cycle();
    chk("t2_first_adr", {56'd0, mem_adr}, 64'h01);
    step();
    eval_cycle();
    chk("t2_second_adr", {56'd0, mem_adr}, 64'h02);
    step();
    chk("t2_b_ack", {63'd0, b_ack}, 64'd1);
    eval_cycle();

    // Saturation: 8 accesses, 4 per master
    do_reset();
    cyc(1);
    acks_seen[0] = 0; acks_seen[1] = 0;
    repeat (8) cyc(1);
    chk("sat_a_count", 64'(acks_seen[0]), 64'd4);
    chk("sat_b_count", 64'(acks_seen[1]), 64'd4);
    repeat (3) cyc(0);

    // Cross write/read of the same address
    do_reset();
    step();
    new_req(0, 1'b1, 8'h05, 32'h0000_1234);
    new_req(1, 1'b0, 8'h05, '0);
    eval_cycle();
    step();
    eval_cycle();
    step();
    chk("cross_b_ack", {63'd0, b_ack}, 64'd1);
    chk("cross_b_dat", {32'd0, b_dout}, 64'h1234);
    eval_cycle();

    // Lone master B back-to-back reads
    do_reset();
    acks_seen[1] = 0;
    for (int n = 0, c = 0; c < 10; c++) begin
      step();
      chk("lone_overlap", {63'd0, mem_stb & b_ack}, 64'd0);
      if (!stb[1] && n < 4) begin
        new_req(1, 1'b0, AW'($urandom_range(31, 0)), '0);
        n++;
      end
      eval_cycle();
    end
    chk("lone_b_count", 64'(acks_seen[1]), 64'd4);

    // Reset in the cycle after A's issue
    do_reset();
    step();
    new_req(0, 1'b0, 8'h10, '0);
    eval_cycle();
    @(posedge clk);
    #2;
    chk("rst_pre_ack", {63'd0, a_ack}, 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_ack", {63'd0, a_ack}, 64'd0);
    stb[0] = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step();
    eval_cycle();
    step();
    new_req(0, 1'b0, 8'h20, '0);
    new_req(1, 1'b0, 8'h21, '0);
    eval_cycle();
    chk("post_rst_gnt_a", {56'd0, mem_adr}, 64'h20);
    repeat (3) cyc(0);

    // Random traffic
    do_reset();
    repeat (400) cyc(2);
    repeat (4) cyc(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
